// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the FSM test-vector sequencer.
// The state encoding, default widths and MISR taps live here so top and MISR agree.
package fsm_seq_pkg;

  localparam int XW_DEF    = 10;
  localparam int YW_DEF    = 12;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int HW_DEF    = 4;

  // Feedback taps on signature bits 11, 5, 3 and 0
  localparam logic [11:0] MISR_TAPS = 12'h829;

  localparam int DRST_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRST  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_misr.sv
// Multiple-input signature register: shifts left with parity feedback from TAPS
// and folds the captured data word in on every capture cycle.
module seq_misr
  import fsm_seq_pkg::*;
#(
  parameter int            YW   = YW_DEF,
  parameter logic [YW-1:0] TAPS = YW'(MISR_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_capture,
  input  logic [YW-1:0] i_data,
  output logic [YW-1:0] o_signature
);

  logic [YW-1:0] r_sig;
  logic          w_fb;

  assign w_fb = ^(r_sig & TAPS);

  // Clear wins over capture so a new run always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_clear) begin
      r_sig <= '0;
    end else if (i_capture) begin
      r_sig <= {r_sig[YW-2:0], w_fb} ^ i_data;
    end
  end

  assign o_signature = r_sig;

endmodule

// File: rtl/fsm_vec_sequencer.sv
// Test sequencer: resets an attached FSM, plays a programmable vector table to it
// with a per-vector hold time, and compacts the FSM outputs into a MISR signature.
module fsm_vec_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int HW    = HW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [XW-1:0] i_cfg_wdata,
  input  logic [AW:0]   i_cfg_len,
  input  logic [HW-1:0] i_hold_cycles,
  input  logic          i_start,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_dut_rst,
  output logic [XW-1:0] o_dut_x,
  input  logic [YW-1:0] i_dut_y,
  output logic [YW-1:0] o_signature,
  output logic [AW:0]   o_vec_count
);

  localparam logic [AW:0] LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);
  localparam logic [1:0]  DRST_LAST = 2'(DRST_CYCLES - 1);

  logic [XW-1:0] r_table [DEPTH];

  seq_state_t    r_state, w_state_nxt;
  logic [1:0]    r_dcnt, w_dcnt_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [AW:0]   r_len;
  logic [HW-1:0] r_hold;
  logic [AW:0]   r_vcnt, w_vcnt_nxt;
  logic          r_err, w_err_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_dut_rst, w_dut_rst_nxt;
  logic [XW-1:0] r_dut_x, w_dut_x_nxt;

  logic w_len_ok, w_accept, w_reject, w_capture, w_cancel, w_last;

  assign w_len_ok = (i_cfg_len != '0) && (i_cfg_len <= LEN_MAX);
  assign w_last   = ({1'b0, r_idx} == (r_len - LEN_ONE));

  // The table has no reset and only accepts writes while idle
  always_ff @(posedge clk) begin
    if (r_state == IDLE && i_cfg_we) begin
      r_table[i_cfg_addr] <= i_cfg_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_idx_nxt   = r_idx;
    w_hcnt_nxt  = r_hcnt;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    w_cancel    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = DRST;
            w_dcnt_nxt  = '0;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      DRST: begin
        if (i_abort) begin
          w_cancel    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_dcnt == DRST_LAST) begin
          w_state_nxt = APPLY;
          w_idx_nxt   = '0;
          w_hcnt_nxt  = r_hold;
        end else begin
          w_dcnt_nxt = r_dcnt + 2'd1;
        end
      end
      APPLY: begin
        // A vector is captured only on the last cycle of its hold window
        if (i_abort) begin
          w_cancel    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_hcnt != '0) begin
          w_hcnt_nxt = r_hcnt - HW'(1);
        end else begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt  = r_idx + AW'(1);
            w_hcnt_nxt = r_hold;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_busy_nxt    = (w_state_nxt == DRST) || (w_state_nxt == APPLY);
    w_done_nxt    = (w_state_nxt == DONE);
    w_dut_rst_nxt = (w_state_nxt != APPLY);
    w_dut_x_nxt   = (w_state_nxt == APPLY) ? r_table[w_idx_nxt] : '0;
    w_err_nxt     = r_err;
    if (w_accept) begin
      w_err_nxt = 1'b0;
    end else if (w_reject || w_cancel) begin
      w_err_nxt = 1'b1;
    end
    w_vcnt_nxt = r_vcnt;
    if (w_accept) begin
      w_vcnt_nxt = '0;
    end else if (w_capture) begin
      w_vcnt_nxt = r_vcnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dcnt    <= '0;
      r_idx     <= '0;
      r_hcnt    <= '0;
      r_len     <= '0;
      r_hold    <= '0;
      r_vcnt    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dut_rst <= 1'b1;
      r_dut_x   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dut_rst <= w_dut_rst_nxt;
      r_dut_x   <= w_dut_x_nxt;
      if (w_accept) begin
        r_len  <= i_cfg_len;
        r_hold <= i_hold_cycles;
      end
    end
  end

  seq_misr #(
    .YW   (YW),
    .TAPS (YW'(MISR_TAPS))
  ) u_misr (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_accept),
    .i_capture   (w_capture),
    .i_data      (i_dut_y),
    .o_signature (o_signature)
  );

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_dut_rst   = r_dut_rst;
  assign o_dut_x     = r_dut_x;
  assign o_vec_count = r_vcnt;

endmodule

// File: doc/fsm_vec_sequencer.md
Name: fsm_vec_sequencer

Overview:
Test-sequencing controller for the benchmark FSM controllers (10 inputs x1..x10, 12 outputs y1..y12).
- Holds a small programmable table of input vectors.
- Resets the attached FSM, plays the vectors to it with a programmable hold time, and compacts its outputs into a 12-bit MISR signature.
- Lets a bench or on-chip checker compare clean and modified FSM instances by signature.

Parameters:
XW, 10, width of one stimulus vector (FSM input count)
YW, 12, width of FSM output bus and of the signature
DEPTH, 16, number of vector table entries
AW, 4, table address width (log2 DEPTH)
HW, 4, width of the hold-cycle field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_wdata  in  XW  table write data
cfg_len  in  AW+1  number of vectors to play, sampled at start, legal 1..DEPTH
hold_cycles  in  HW  extra cycles each vector is held, sampled at start
start  in  1  run request, single-cycle
abort  in  1  cancel run
busy  out  1  run in progress (DRST or APPLY)
done  out  1  one-cycle pulse on normal completion
err  out  1  last start rejected or last run aborted
dut_rst  out  1  reset to attached FSM
dut_x  out  XW  FSM input vector
dut_y  in  YW  FSM outputs
signature  out  YW  MISR value
vec_count  out  AW+1  vectors fully captured in current or last run

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, dut_rst=1, dut_x=0, signature=0, vec_count=0, state IDLE.
  - Table contents undefined. The table has no reset.
- All outputs are registered.
- States: IDLE, DRST, APPLY, DONE.
- IDLE:
  - dut_rst=1, dut_x=0.
  - cfg_we writes table[cfg_addr]=cfg_wdata. Writes are ignored in every other state.
  - start with abort=0:
    - cfg_len in 1..DEPTH: latch len and hold, clear signature, vec_count and err, go to DRST.
    - Otherwise: err=1, stay in IDLE.
  - abort has priority over start in the same cycle; the start is dropped.
- DRST:
  - Exactly 2 cycles, dut_rst=1, busy=1, dut_x=0.
  - Then APPLY with idx=0 and hcnt=hold.
- APPLY:
  - dut_rst=0, busy=1, dut_x=table[idx].
  - If hcnt!=0: hcnt decrements.
  - If hcnt==0: capture dut_y into the MISR and increment vec_count.
    - idx==len-1: go to DONE.
    - Otherwise: idx++, hcnt=hold.
  - Each vector is driven for hold+1 cycles and captured on its last cycle.
  - Busy length = 2+len*(hold+1) cycles.
- DONE:
  - One cycle: done=1, busy=0, dut_rst=1, then IDLE.
  - signature and vec_count hold until the next accepted start.
- abort in DRST or APPLY:
  - Next state IDLE, err=1, no done pulse.
  - signature and vec_count keep their partial values.
  - abort in DONE or IDLE has no effect.
- start while busy or in DONE: ignored.
- MISR update (capture cycle only), s=signature:
  - fb = s[11]^s[5]^s[3]^s[0].
  - s_next = {s[10:0], fb} ^ dut_y.
- idx and hcnt never wrap. len=DEPTH uses table entries 0..DEPTH-1.
- Asynchronous rst mid-run forces the reset values immediately, including dut_rst=1.

Decomposition:
- Shared package fsm_seq_pkg: state enum (IDLE, DRST, APPLY, DONE), default widths, MISR tap constant 12'h829 (bits 11,5,3,0), DRST length constant 2.
- One sub-module, seq_misr: YW-wide MISR.
  - Inputs: clear, capture enable, data.
  - Output: registered signature.
  - Tap mask is a parameter.

Test Plan:
- Single vector: write table[0]=10'h3FF, len=1, hold=0, dut_y tied 12'h001, start → dut_rst high for 2 cycles, dut_x=3FF for 1 cycle, done on the following cycle, signature=12'h001, vec_count=1, busy high 3 cycles.
- Two vectors: len=2, hold=0, dut_y=12'h001 → signature 12'h001 then 12'h002, done after 4 busy cycles.
- Hold: len=3, hold=2, dut_y=0, table 10'h001/002/004 → each vector on dut_x for 3 cycles, signature=0, busy 11 cycles.
- Illegal start: cfg_len=0, then cfg_len=17 → err=1, state stays IDLE, busy=0. A following legal start clears err.
- Abort after 2 captures (len=8) → IDLE next cycle, err=1, no done, vec_count=2, dut_rst=1. cfg_we during the run did not change the table (readback on the next run).
- Async rst asserted mid-APPLY → all outputs at reset values without waiting for a clock edge. start and abort in the same IDLE cycle → no run.
